dmem_ctrl: RTL and testbench

- Load/store unit directly downstream of the datapath data port. Consumes the ALU address, rs2 store data and funct3; returns load data for the register-file writeback mux.
- Bridges to a word-addressed data memory bus with req/ack handshake. Stalls the single-cycle core (freezes PC, suppresses regfile write) until the access completes.
- Handles byte/half/word lane steering, byte enables, load sign/zero extension and alignment faults.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_load_ext.sv | 35 +++
 rtl/dmem_ctrl.sv | 161 ++++++++++++++++
 tb/tb_dmem_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory load/store controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // funct3 encodings; load and store share numeric values for byte/half/word.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/dmem_load_ext.sv
// Combinational load lane extraction with sign/zero extension.
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    data = word;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store unit bridging the core data port to a req/ack word bus.
// Optional bus timeout is enabled by defining DMEM_TIMEOUT_EN.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_re,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_funct3,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  state_t      state;
  logic        acc;
  logic        f3_ok;
  logic        misaligned;
  logic        bad;
  logic        accept;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [31:0] rdata_q;
  logic [31:0] load_data;
  logic        idle_bad;

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] busy_cnt;
  logic             fault_q;
`endif

  // Request qualification; a simultaneous load+store is treated as a store.
  always_comb begin
    acc = cpu_re | cpu_we;
    if (cpu_we) f3_ok = cpu_funct3 inside {F3_SB, F3_SH, F3_SW};
    else        f3_ok = cpu_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    case (cpu_funct3[1:0])
      2'b01:   misaligned = cpu_addr[0];
      2'b10:   misaligned = |cpu_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    bad    = acc & (~f3_ok | misaligned);
    accept = (state == IDLE) & acc & ~bad;
  end

  always_comb begin
    be_next    = BE_WORD;
    wdata_next = '0;
    if (cpu_we) begin
      case (cpu_funct3)
        F3_SB: begin
          be_next    = BE_BYTE0 << cpu_addr[1:0];
          wdata_next = {4{cpu_wdata[7:0]}};
        end
        F3_SH: begin
          be_next    = cpu_addr[1] ? BE_HI_HALF : BE_LO_HALF;
          wdata_next = {2{cpu_wdata[15:0]}};
        end
        default: begin
          be_next    = BE_WORD;
          wdata_next = cpu_wdata;
        end
      endcase
    end
  end

  dmem_load_ext u_load_ext (
    .funct3  (funct3_q),
    .addr_lo (lane_q),
    .word    (bus_rdata),
    .data    (load_data)
  );

  assign idle_bad  = (state == IDLE) & bad;
  assign cpu_stall = accept | (state == BUSY);
  assign cpu_rdata = idle_bad ? 32'd0 : rdata_q;
`ifdef DMEM_TIMEOUT_EN
  assign cpu_fault = idle_bad | fault_q;
`else
  assign cpu_fault = idle_bad;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= BE_NONE;
      bus_wdata <= '0;
      funct3_q  <= '0;
      lane_q    <= '0;
      rdata_q   <= '0;
`ifdef DMEM_TIMEOUT_EN
      busy_cnt  <= '0;
      fault_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= BUSY;
            bus_req   <= 1'b1;
            bus_we    <= cpu_we;
            bus_addr  <= {cpu_addr[31:2], 2'b00};
            bus_be    <= be_next;
            bus_wdata <= wdata_next;
            funct3_q  <= cpu_funct3;
            lane_q    <= cpu_addr[1:0];
`ifdef DMEM_TIMEOUT_EN
            busy_cnt  <= '0;
`endif
          end
        end
        BUSY: begin
          // An ack arriving in the expiry cycle takes priority over the timeout.
          if (bus_ack) begin
            state   <= DONE;
            bus_req <= 1'b0;
            if (!bus_we) rdata_q <= load_data;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (busy_cnt == TO_LAST) begin
            state   <= DONE;
            bus_req <= 1'b0;
            rdata_q <= '0;
            fault_q <= 1'b1;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
`ifdef DMEM_TIMEOUT_EN
          fault_q <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: vector table plus hand-written corner sequences.
module tb_dmem_ctrl;

`ifdef DMEM_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic        clk;
  logic        reset_n;
  logic        cpu_re, cpu_we;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall, cpu_fault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  dmem_ctrl #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_re     (cpu_re),
    .cpu_we     (cpu_we),
    .cpu_funct3 (cpu_funct3),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .cpu_fault  (cpu_fault),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        re;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;     // word returned by the bus
    int          delay;     // BUSY cycles without ack before the ack cycle
    logic        exp_fault;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_load;  // extended load result (loads only)
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata;
  logic [31:0] sb_q[$];
  vec_t        vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic re, input logic we,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int delay, input logic fault,
                              input logic [3:0] be, input logic [31:0] ewdata,
                              input logic [31:0] eload);
    vec_t v;
    v.name = name; v.re = re; v.we = we; v.f3 = f3; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.delay = delay; v.exp_fault = fault;
    v.exp_addr = {addr[31:2], 2'b00}; v.exp_be = be; v.exp_wdata = ewdata;
    v.exp_load = eload;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    int stall_cnt;
    @(negedge clk);
    cpu_re = v.re; cpu_we = v.we; cpu_funct3 = v.f3; cpu_addr = v.addr; cpu_wdata = v.wdata;
    #1;
    if (v.exp_fault) begin
      check({v.name, " fault"}, {31'd0, cpu_fault}, 32'd1);
      check({v.name, " stall"}, {31'd0, cpu_stall}, 32'd0);
      check({v.name, " rdata0"}, cpu_rdata, 32'd0);
      @(posedge clk);
      @(negedge clk);
      check({v.name, " no req"}, {31'd0, bus_req}, 32'd0);
      cpu_re = 1'b0; cpu_we = 1'b0;
      #1;
      check({v.name, " fault clr"}, {31'd0, cpu_fault}, 32'd0);
      check({v.name, " rdata hold"}, cpu_rdata, last_rdata);
      return;
    end
    check({v.name, " fault0"}, {31'd0, cpu_fault}, 32'd0);
    stall_cnt = int'(cpu_stall);
    // Scoreboard: loads produce a new value; stores leave the previous one.
    if (!v.we) last_rdata = v.exp_load;
    sb_q.push_back(last_rdata);
    @(posedge clk);
    for (int i = 0; i <= v.delay; i++) begin
      @(negedge clk);
      stall_cnt += int'(cpu_stall);
      check({v.name, " req"}, {31'd0, bus_req}, 32'd1);
      if (i == 0) begin
        check({v.name, " we"}, {31'd0, bus_we}, {31'd0, v.we});
        check({v.name, " addr"}, bus_addr, v.exp_addr);
        check({v.name, " be"}, {28'd0, bus_be}, {28'd0, v.exp_be});
        if (v.we) check({v.name, " wdata"}, bus_wdata, v.exp_wdata);
      end
      if (i == v.delay) begin
        bus_ack = 1'b1;
        bus_rdata = v.rdata;
      end
    end
    @(negedge clk);
    bus_ack = 1'b0;
    bus_rdata = 32'h5A5A_5A5A;
    check({v.name, " done req"}, {31'd0, bus_req}, 32'd0);
    check({v.name, " done stall"}, {31'd0, cpu_stall}, 32'd0);
    check({v.name, " done fault"}, {31'd0, cpu_fault}, 32'd0);
    check({v.name, " stall cycles"}, stall_cnt, v.delay + 2);
    if (sb_q.size() == 0) check({v.name, " scoreboard empty"}, 32'd0, 32'd1);
    else check({v.name, " rdata"}, cpu_rdata, sb_q.pop_front());
    @(posedge clk);
    @(negedge clk);
    cpu_re = 1'b0; cpu_we = 1'b0;
    #1;
    check({v.name, " no reissue"}, {31'd0, bus_req}, 32'd0);
  endtask

  initial begin
    vecs[0]  = mk("SW 0x10",  0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1, 0, 4'b1111, 32'hDEADBEEF, 32'h0);
    vecs[1]  = mk("SB 0x13",  0, 1, 3'b000, 32'h13, 32'h000000A5, 32'h0, 0, 0, 4'b1000, 32'hA5A5A5A5, 32'h0);
    vecs[2]  = mk("SH 0x16",  0, 1, 3'b001, 32'h16, 32'h1234BEEF, 32'h0, 0, 0, 4'b1100, 32'hBEEFBEEF, 32'h0);
    vecs[3]  = mk("LB 0x21",  1, 0, 3'b000, 32'h21, 32'h0, 32'h00008000, 0, 0, 4'b1111, 32'h0, 32'hFFFFFF80);
    vecs[4]  = mk("LBU 0x21", 1, 0, 3'b100, 32'h21, 32'h0, 32'h00008000, 2, 0, 4'b1111, 32'h0, 32'h00000080);
    vecs[5]  = mk("LH 0x22",  1, 0, 3'b001, 32'h22, 32'h0, 32'h80010000, 0, 0, 4'b1111, 32'h0, 32'hFFFF8001);
    vecs[6]  = mk("LHU 0x20", 1, 0, 3'b101, 32'h20, 32'h0, 32'h1234F00D, 1, 0, 4'b1111, 32'h0, 32'h0000F00D);
    vecs[7]  = mk("SB 0x11",  0, 1, 3'b000, 32'h11, 32'hFFFFFF3C, 32'h0, 0, 0, 4'b0010, 32'h3C3C3C3C, 32'h0);
    vecs[8]  = mk("LW 0x6",   1, 0, 3'b010, 32'h06, 32'h0, 32'h0, 0, 1, 4'b0000, 32'h0, 32'h0);
    vecs[9]  = mk("LB f3=011", 1, 0, 3'b011, 32'h20, 32'h0, 32'h0, 0, 1, 4'b0000, 32'h0, 32'h0);
    vecs[10] = mk("SH 0x11",  0, 1, 3'b001, 32'h11, 32'h0, 32'h0, 0, 1, 4'b0000, 32'h0, 32'h0);
    vecs[11] = mk("S f3=100", 0, 1, 3'b100, 32'h10, 32'h0, 32'h0, 0, 1, 4'b0000, 32'h0, 32'h0);
    vecs[12] = mk("RE+WE SW", 1, 1, 3'b010, 32'h30, 32'h01234567, 32'hFFFFFFFF, 0, 0, 4'b1111, 32'h01234567, 32'h0);
    vecs[13] = mk("LB 0x23",  1, 0, 3'b000, 32'h23, 32'h0, 32'h7F000000, 0, 0, 4'b1111, 32'h0, 32'h0000007F);
    vecs[14] = mk("LW 0x24",  1, 0, 3'b010, 32'h24, 32'h0, 32'hCAFEBABE, 3, 0, 4'b1111, 32'h0, 32'hCAFEBABE);

    reset_n = 1'b0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_funct3 = 3'b000;
    cpu_addr = '0; cpu_wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
    last_rdata = '0;
    #1;
    check("reset req", {31'd0, bus_req}, 32'd0);
    check("reset be", {28'd0, bus_be}, 32'd0);
    check("reset rdata", cpu_rdata, 32'd0);
    check("reset stall", {31'd0, cpu_stall}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Ack while idle must not start or complete anything.
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'h11111111;
    @(posedge clk);
    @(negedge clk);
    bus_ack = 1'b0;
    check("idle ack req", {31'd0, bus_req}, 32'd0);
    check("idle ack stall", {31'd0, cpu_stall}, 32'd0);
    check("idle ack rdata", cpu_rdata, last_rdata);

    // Reset asserted mid-access clears everything asynchronously.
    @(negedge clk);
    cpu_we = 1'b1; cpu_funct3 = 3'b010; cpu_addr = 32'h40; cpu_wdata = 32'h87654321;
    @(posedge clk);
    @(negedge clk);
    check("pre-reset req", {31'd0, bus_req}, 32'd1);
    #2;
    cpu_we = 1'b0;
    reset_n = 1'b0;
    #1;
    check("async rst req", {31'd0, bus_req}, 32'd0);
    check("async rst we", {31'd0, bus_we}, 32'd0);
    check("async rst addr", bus_addr, 32'd0);
    check("async rst be", {28'd0, bus_be}, 32'd0);
    check("async rst wdata", bus_wdata, 32'd0);
    check("async rst rdata", cpu_rdata, 32'd0);
    check("async rst fault", {31'd0, cpu_fault}, 32'd0);
    check("async rst stall", {31'd0, cpu_stall}, 32'd0);
    last_rdata = '0;
    @(negedge clk);
    reset_n = 1'b1;
    apply(vecs[0]);

`ifdef DMEM_TIMEOUT_EN
    begin
      int req_cycles;
      req_cycles = 0;
      @(negedge clk);
      cpu_re = 1'b1; cpu_funct3 = 3'b010; cpu_addr = 32'h50;
      @(posedge clk);
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (!bus_req) break;
        req_cycles++;
      end
      check("timeout busy cycles", req_cycles, TB_TIMEOUT);
      check("timeout done fault", {31'd0, cpu_fault}, 32'd1);
      check("timeout done rdata", cpu_rdata, 32'd0);
      check("timeout done stall", {31'd0, cpu_stall}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      cpu_re = 1'b0;
      #1;
      check("timeout fault clr", {31'd0, cpu_fault}, 32'd0);
      last_rdata = '0;
    end
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
